// File: rtl/reg_file_arbiter_if.sv
// Bus bundle between the two register-file clients, the arbiter and the register file ports.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface reg_file_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
);
  logic              c0_req;
  logic              c0_we;
  logic [ADDR_W-1:0] c0_addr;
  logic [DATA_W-1:0] c0_wdata;
  logic              c0_gnt;
  logic              c0_rvalid;
  logic [DATA_W-1:0] c0_rdata;

  logic              c1_req;
  logic              c1_we;
  logic [ADDR_W-1:0] c1_addr;
  logic [DATA_W-1:0] c1_wdata;
  logic              c1_gnt;
  logic              c1_rvalid;
  logic [DATA_W-1:0] c1_rdata;

  logic              rf_write;
  logic [ADDR_W-1:0] rf_addr_in;
  logic [DATA_W-1:0] rf_data_in;
  logic [ADDR_W-1:0] rf_addr_out0;
  logic [DATA_W-1:0] rf_data_out0;

  modport slave (
    input  c0_req, c0_we, c0_addr, c0_wdata,
    output c0_gnt, c0_rvalid, c0_rdata,
    input  c1_req, c1_we, c1_addr, c1_wdata,
    output c1_gnt, c1_rvalid, c1_rdata,
    output rf_write, rf_addr_in, rf_data_in, rf_addr_out0,
    input  rf_data_out0
  );

  modport master (
    output c0_req, c0_we, c0_addr, c0_wdata,
    input  c0_gnt, c0_rvalid, c0_rdata,
    output c1_req, c1_we, c1_addr, c1_wdata,
    input  c1_gnt, c1_rvalid, c1_rdata,
    input  rf_write, rf_addr_in, rf_data_in, rf_addr_out0,
    output rf_data_out0
  );
endinterface

// File: rtl/reg_file_arbiter.sv
// Two-client register-file slot arbiter: clears registers 1..DEPTH-1 after reset, then grants
// client 0 by priority unless client 1 has been blocked MAX_WAIT cycles in a row.
//
// state | meaning
// INIT  | clearing one register per cycle from address 1 up to DEPTH-1; no grants
// RUN   | arbitrating client traffic onto the write port and read port 0
module reg_file_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int DATA_W   = 64,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                init_done,
  reg_file_arbiter_if.slave   bus
);

  localparam int AGE_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [AGE_W-1:0]  age;
  logic [1:0]        rd_pend;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic              clr_active;
  logic              c1_prio;
  logic              gnt0;
  logic              gnt1;
  logic              any_gnt;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              wr_issue;
  logic              rd_issue;

  always_comb begin
    c1_prio  = (age == AGE_W'(MAX_WAIT));
    gnt1     = (state == RUN) && bus.c1_req && (c1_prio || !bus.c0_req);
    gnt0     = (state == RUN) && bus.c0_req && !gnt1;
    any_gnt  = gnt0 || gnt1;
    g_we     = gnt1 ? bus.c1_we    : bus.c0_we;
    g_addr   = gnt1 ? bus.c1_addr  : bus.c0_addr;
    g_wdata  = gnt1 ? bus.c1_wdata : bus.c0_wdata;
    wr_issue = any_gnt && g_we;
    rd_issue = any_gnt && !g_we;
  end

  // Gated with rst_n so the clear write is not presented while reset is held.
  assign clr_active = (state == INIT) && rst_n;

  assign bus.c0_gnt       = gnt0;
  assign bus.c1_gnt       = gnt1;
  assign bus.rf_write     = clr_active || wr_issue;
  assign bus.rf_addr_in   = clr_active ? clr_ptr : (wr_issue ? g_addr  : '0);
  assign bus.rf_data_in   = wr_issue ? g_wdata : '0;
  assign bus.rf_addr_out0 = rd_issue ? g_addr : rd_addr_q;

  // Read data passes straight through in the response cycle and is held afterwards.
  assign bus.c0_rvalid = rd_pend[0];
  assign bus.c1_rvalid = rd_pend[1];
  assign bus.c0_rdata  = rd_pend[0] ? bus.rf_data_out0 : rdata0_q;
  assign bus.c1_rdata  = rd_pend[1] ? bus.rf_data_out0 : rdata1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      clr_ptr   <= ADDR_W'(1);
      age       <= '0;
      init_done <= 1'b0;
      rd_pend   <= 2'b00;
      rd_addr_q <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rd_pend <= {gnt1 && !g_we, gnt0 && !g_we};
      if (rd_issue)   rd_addr_q <= g_addr;
      if (rd_pend[0]) rdata0_q  <= bus.rf_data_out0;
      if (rd_pend[1]) rdata1_q  <= bus.rf_data_out0;

      case (state)
        INIT: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          // Aging only counts real contention, so requests parked during the clear start fresh.
          if (!bus.c1_req || gnt1) age <= '0;
          else if (!c1_prio)       age <= age + 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Bench for reg_file_arbiter: behavioural register file plus a cycle-level scoreboard of
// expected grants, port activity and read responses, driven by directed and random requests.
module tb_reg_file_arbiter;

  localparam int ADDR_W   = 5;
  localparam int DEPTH    = 32;
  localparam int DATA_W   = 64;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done;

  reg_file_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  reg_file_arbiter #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  // Register file: synchronous write ignoring address 0, registered read with address 0 = 0.
  // Contents are scrambled while reset is held so the clear sequence really matters.
  logic [DATA_W-1:0] rf_mem [DEPTH];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rf_mem[i] <= 64'hBAD0_0000_0000_0000 | 64'(i);
    end else if (bus.rf_write && bus.rf_addr_in != 0) begin
      rf_mem[bus.rf_addr_in] <= bus.rf_data_in;
    end
    bus.rf_data_out0 <= (bus.rf_addr_out0 == 0) ? '0 : rf_mem[bus.rf_addr_out0];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard state
  logic [DATA_W-1:0] sb_mem [DEPTH];
  int                clr_cnt;
  int                blocked;
  bit                pend_rd;
  int                pend_cl;
  logic [DATA_W-1:0] pend_val;
  logic [DATA_W-1:0] last_rd [2];
  logic [ADDR_W-1:0] last_raddr;
  bit                gseen [2];

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) sb_mem[i] = '0;
    clr_cnt    = 0;
    blocked    = 0;
    pend_rd    = 0;
    pend_cl    = 0;
    pend_val   = '0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    last_raddr = '0;
    gseen[0]   = 0;
    gseen[1]   = 0;
  endtask

  task automatic check_cycle();
    bit                e_g0, e_g1, we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    chk("c0_rvalid", bus.c0_rvalid, pend_rd && pend_cl == 0);
    chk("c1_rvalid", bus.c1_rvalid, pend_rd && pend_cl == 1);
    if (pend_rd) last_rd[pend_cl] = pend_val;
    chk("c0_rdata", bus.c0_rdata, last_rd[0]);
    chk("c1_rdata", bus.c1_rdata, last_rd[1]);
    pend_rd = 0;
    if (clr_cnt < DEPTH - 1) begin
      chk("init_done_clr", init_done, 0);
      chk("c0_gnt_clr", bus.c0_gnt, 0);
      chk("c1_gnt_clr", bus.c1_gnt, 0);
      chk("rf_write_clr", bus.rf_write, 1);
      chk("rf_addr_in_clr", bus.rf_addr_in, clr_cnt + 1);
      chk("rf_data_in_clr", bus.rf_data_in, 0);
      chk("rf_addr_out0_clr", bus.rf_addr_out0, last_raddr);
      clr_cnt++;
      gseen[0] = 0;
      gseen[1] = 0;
    end else begin
      chk("init_done", init_done, 1);
      e_g1 = bus.c1_req && (blocked == MAX_WAIT || !bus.c0_req);
      e_g0 = bus.c0_req && !e_g1;
      chk("c0_gnt", bus.c0_gnt, e_g0);
      chk("c1_gnt", bus.c1_gnt, e_g1);
      if (bus.c1_req && !e_g1) blocked = (blocked < MAX_WAIT) ? blocked + 1 : MAX_WAIT;
      else                     blocked = 0;
      if (e_g0 || e_g1) begin
        we = e_g1 ? bus.c1_we    : bus.c0_we;
        a  = e_g1 ? bus.c1_addr  : bus.c0_addr;
        d  = e_g1 ? bus.c1_wdata : bus.c0_wdata;
        if (we) begin
          chk("rf_write_wr", bus.rf_write, 1);
          chk("rf_addr_in", bus.rf_addr_in, a);
          chk("rf_data_in", bus.rf_data_in, d);
          if (a != 0) sb_mem[a] = d;
        end else begin
          chk("rf_write_rd", bus.rf_write, 0);
          chk("rf_addr_out0", bus.rf_addr_out0, a);
          pend_rd    = 1;
          pend_cl    = e_g1 ? 1 : 0;
          pend_val   = (a == 0) ? '0 : sb_mem[a];
          last_raddr = a;
        end
      end else begin
        chk("rf_write_idle", bus.rf_write, 0);
        chk("rf_addr_out0_hold", bus.rf_addr_out0, last_raddr);
      end
      gseen[0] = e_g0;
      gseen[1] = e_g1;
    end
  endtask

  // Inputs are changed just after a rising edge; outputs are checked on the falling edge.
  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input bit r, input bit we,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (k == 0) begin
      bus.c0_req = r; bus.c0_we = we; bus.c0_addr = a; bus.c0_wdata = d;
    end else begin
      bus.c1_req = r; bus.c1_we = we; bus.c1_addr = a; bus.c1_wdata = d;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_init_done", init_done, 0);
      chk("rst_c0_gnt", bus.c0_gnt, 0);
      chk("rst_c1_gnt", bus.c1_gnt, 0);
      chk("rst_c0_rvalid", bus.c0_rvalid, 0);
      chk("rst_c1_rvalid", bus.c1_rvalid, 0);
      chk("rst_c0_rdata", bus.c0_rdata, 0);
      chk("rst_c1_rdata", bus.c1_rdata, 0);
      chk("rst_rf_write", bus.rf_write, 0);
      chk("rst_rf_addr_in", bus.rf_addr_in, 0);
      chk("rst_rf_data_in", bus.rf_data_in, 0);
      chk("rst_rf_addr_out0", bus.rf_addr_out0, 0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  // Holds one request until it is granted, then drops it.
  task automatic issue(input int k, input bit we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    set_req(k, 1, we, a, d);
    for (int i = 0; i < 40; i++) begin
      step();
      if (gseen[k]) break;
    end
    chk("issue_granted", gseen[k], 1);
    set_req(k, 0, 0, '0, '0);
  endtask

  task automatic run_held(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (gseen[0]) bus.c0_req = 0;
      if (gseen[1]) bus.c1_req = 0;
    end
  endtask

  initial begin
    int waits;
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    @(posedge clk);
    #1;
    do_reset(3);

    // Clear sequence with idle clients, then a few idle RUN cycles.
    run_held(DEPTH + 3);

    // Write then read back on the next cycle.
    issue(0, 1, 5'd5, 64'hDEAD);
    issue(0, 0, 5'd5, '0);
    step();
    chk("rd5_value", bus.c0_rdata, 64'hDEAD);

    // Client 1 starved by continuous client 0 traffic until aging kicks in.
    set_req(0, 1, 1, 5'd7, 64'h1234_5678);
    set_req(1, 1, 0, 5'd3, '0);
    waits = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (gseen[1]) break;
      waits++;
    end
    chk("c1_wait_cycles", waits, MAX_WAIT);
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    run_held(2);

    // Address 0 reads as zero, writes to it are dropped.
    issue(0, 0, 5'd0, '0);
    step();
    chk("rd0_c0", bus.c0_rdata, 0);
    issue(1, 1, 5'd0, 64'hFF);
    issue(1, 0, 5'd0, '0);
    step();
    chk("rd0_c1", bus.c1_rdata, 0);

    // Reset lands while a client 1 read response is pending.
    issue(1, 1, 5'd9, 64'hCAFE_F00D);
    issue(1, 0, 5'd9, '0);
    do_reset(2);

    // Both clients wait through the clear; client 0 wins first.
    set_req(0, 1, 1, 5'd2, 64'hA5A5);
    set_req(1, 1, 0, 5'd2, '0);
    run_held(DEPTH + 4);

    // Random traffic.
    for (int c = 0; c < 500; c++) begin
      for (int k = 0; k < 2; k++) begin
        bit cur;
        cur = (k == 0) ? bus.c0_req : bus.c1_req;
        if (!cur && $urandom_range(0, 2) != 0)
          set_req(k, 1, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom),
                  {$urandom, $urandom});
      end
      step();
      if (gseen[0]) bus.c0_req = 0;
      if (gseen[1]) bus.c1_req = 0;
    end
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    run_held(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
